// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester handshake and CDB broadcast bundle for cdb_arbiter
interface cdb_arbiter_if #(
   parameter int N_REQ  = 5,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*TAG_W-1:0]  req_tag;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [TAG_W+DATA_W-1:0] cdb1;
   logic [TAG_W+DATA_W-1:0] cdb2;
   logic [TAG_W+DATA_W-1:0] cdb3;
   logic                    cdb_busy;

   modport master (
      output req_valid, req_tag, req_data,
      input  req_ready, cdb1, cdb2, cdb3, cdb_busy
   );

   modport slave (
      input  req_valid, req_tag, req_data,
      output req_ready, cdb1, cdb2, cdb3, cdb_busy
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - rotating-priority scheduler of FU results onto three CDBs
// Optional synchronous flush port enabled by CDB_ARB_FLUSH_EN.
module cdb_arbiter #(
   parameter int N_REQ  = 5,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef CDB_ARB_FLUSH_EN
   input  logic         flush,
`endif
   cdb_arbiter_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = TAG_W + DATA_W;

   logic [N_REQ-1:0]  hold_valid;
   logic [TAG_W-1:0]  hold_tag  [N_REQ];
   logic [DATA_W-1:0] hold_data [N_REQ];
   logic [PW-1:0]     ptr;
   logic [CW-1:0]     cdb_q [3];
   logic              busy_q;

   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  ready;
   logic [N_REQ-1:0]  accept;
   logic [N_REQ-1:0]  hold_valid_nxt;
   logic [2:0]        slot_vld;
   logic [PW-1:0]     slot_idx [3];
   logic [PW-1:0]     ptr_nxt;
   logic              flush_i;

`ifdef CDB_ARB_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Scan from ptr in wrapping order; the last grant in scan order sets the next ptr.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      logic [1:0]    cnt;
      grant    = '0;
      slot_vld = '0;
      for (int s = 0; s < 3; s++) slot_idx[s] = '0;
      ptr_nxt  = ptr;
      cnt      = 2'd0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
         idx = sum[PW-1:0];
         if (!flush_i && hold_valid[idx] && cnt != 2'd3) begin
            grant[idx]    = 1'b1;
            slot_vld[cnt] = 1'b1;
            slot_idx[cnt] = idx;
            ptr_nxt       = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
            cnt           = cnt + 2'd1;
         end
      end
   end

   assign ready          = flush_i ? '0 : (~hold_valid | grant);
   assign accept         = bus.req_valid & ready;
   assign hold_valid_nxt = (hold_valid & ~grant) | accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= '0;
         ptr        <= '0;
         busy_q     <= 1'b0;
         for (int s = 0; s < 3; s++) cdb_q[s] <= '0;
      end else if (flush_i) begin
         hold_valid <= '0;
         ptr        <= '0;
         busy_q     <= 1'b0;
         for (int s = 0; s < 3; s++) cdb_q[s] <= '0;
      end else begin
         hold_valid <= hold_valid_nxt;
         ptr        <= ptr_nxt;
         busy_q     <= |hold_valid_nxt;
         for (int s = 0; s < 3; s++)
            cdb_q[s] <= slot_vld[s] ? {hold_tag[slot_idx[s]], hold_data[slot_idx[s]]} : '0;
      end
   end

   // Payload is qualified by hold_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (accept[i]) begin
            hold_tag[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
            hold_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.cdb1      = cdb_q[0];
   assign bus.cdb2      = cdb_q[1];
   assign bus.cdb3      = cdb_q[2];
   assign bus.cdb_busy  = busy_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;
   localparam int N  = 5;
   localparam int TW = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
`ifdef CDB_ARB_FLUSH_EN
   logic flush = 1'b0;
`endif

   cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef CDB_ARB_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic              m_hv   [N];
   logic [TW-1:0]     m_tag  [N];
   logic [DW-1:0]     m_data [N];
   logic              m_gnt  [N];
   logic [TW+DW-1:0]  m_cdb  [3];
   int                m_ptr;
   logic              m_busy;
   logic              m_flush;
   int                gq[$];

   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i])
               assert (bus.req_tag[i*TW +: TW] != '0)
                  else $error("tag 0 presented on requester %0d", i);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      for (int s = 0; s < 3; s++) m_cdb[s] = '0;
      m_ptr  = 0;
      m_busy = 1'b0;
   endfunction

   // Valid holds taken in rotating order starting at the pointer, at most three.
   function automatic void model_arb();
      gq.delete();
      for (int i = 0; i < N; i++) m_gnt[i] = 1'b0;
      if (!m_flush) begin
         for (int d = 0; d < N; d++) begin
            int i;
            i = (m_ptr + d) % N;
            if (m_hv[i] && gq.size() < 3) begin
               gq.push_back(i);
               m_gnt[i] = 1'b1;
            end
         end
      end
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = !m_flush && (!m_hv[i] || m_gnt[i]);
      return r;
   endfunction

   function automatic void model_edge(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                                      input logic [N*DW-1:0] d, input logic [N-1:0] rdy);
      if (m_flush) begin
         model_reset();
         return;
      end
      for (int s = 0; s < 3; s++) begin
         m_cdb[s] = '0;
         if (s < gq.size()) m_cdb[s] = {m_tag[gq[s]], m_data[gq[s]]};
      end
      if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % N;
      for (int i = 0; i < N; i++) begin
         if (v[i] && rdy[i]) begin
            m_hv[i]   = 1'b1;
            m_tag[i]  = t[i*TW +: TW];
            m_data[i] = d[i*DW +: DW];
         end else if (m_gnt[i]) begin
            m_hv[i] = 1'b0;
         end
      end
      m_busy = 1'b0;
      for (int i = 0; i < N; i++) m_busy = m_busy | m_hv[i];
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                       input logic [N*DW-1:0] d, input logic fl);
      logic [N-1:0] rdy;
      bus.req_valid = v;
      bus.req_tag   = t;
      bus.req_data  = d;
`ifdef CDB_ARB_FLUSH_EN
      flush = fl;
`endif
      m_flush = fl;
      #1;
      model_arb();
      rdy = model_ready();
      chk("cdb1", 64'(bus.cdb1), 64'(m_cdb[0]));
      chk("cdb2", 64'(bus.cdb2), 64'(m_cdb[1]));
      chk("cdb3", 64'(bus.cdb3), 64'(m_cdb[2]));
      chk("busy", 64'(bus.cdb_busy), 64'(m_busy));
      chk("ready", 64'(bus.req_ready), 64'(rdy));
      @(posedge clk);
      model_edge(v, t, d, rdy);
      @(negedge clk);
   endtask

   task automatic idle();
      step('0, '0, '0, 1'b0);
   endtask

   task automatic rand_vec(output logic [N*TW-1:0] t, output logic [N*DW-1:0] d);
      for (int i = 0; i < N; i++) begin
         t[i*TW +: TW] = TW'($urandom_range(1, 63));
         d[i*DW +: DW] = $urandom;
      end
   endtask

   initial begin
      logic [N*TW-1:0] t;
      logic [N*DW-1:0] d;
      logic [N-1:0]    v;
      logic [N-1:0]    ones;
      logic            fl;

      ones = '1;
      m_flush = 1'b0;
      bus.req_valid = '0;
      bus.req_tag   = '0;
      bus.req_data  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_ready", 64'(bus.req_ready), 64'(ones));
      chk("reset_cdb1", 64'(bus.cdb1), 64'd0);
      chk("reset_busy", 64'(bus.cdb_busy), 64'd0);
      @(negedge clk);
      idle();

      // Single requester: req 2, tag 5, data DEADBEEF
      t = '0; d = '0;
      t[2*TW +: TW] = 6'd5;
      d[2*DW +: DW] = 32'hDEADBEEF;
      step(5'b00100, t, d, 1'b0);
      idle();
      chk("single_cdb1", 64'(bus.cdb1), 64'h05_DEADBEEF);
      chk("single_cdb2", 64'(bus.cdb2), 64'd0);
      chk("single_cdb3", 64'(bus.cdb3), 64'd0);
      idle();
      chk("single_once", 64'(bus.cdb1), 64'd0);
      idle();

      // Back-to-back on requester 0 with tags 1,2,3
      for (int k = 1; k <= 3; k++) begin
         t = '0; d = '0;
         t[TW-1:0] = TW'(k);
         d[DW-1:0] = 32'h1000 + DW'(k);
         step(5'b00001, t, d, 1'b0);
         chk("b2b_ready0", 64'(bus.req_ready[0]), 64'd1);
         if (k >= 2) chk("b2b_tag", 64'(bus.cdb1[TW+DW-1:DW]), 64'(k - 1));
      end
      idle();
      chk("b2b_tag3", 64'(bus.cdb1[TW+DW-1:DW]), 64'd3);
      idle();

      // Five requesters streaming every cycle
      for (int c = 0; c < 30; c++) begin
         rand_vec(t, d);
         step(5'b11111, t, d, 1'b0);
      end

      // Asynchronous reset mid-stream with holds and CDBs busy
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cdb1", 64'(bus.cdb1), 64'd0);
      chk("arst_cdb2", 64'(bus.cdb2), 64'd0);
      chk("arst_cdb3", 64'(bus.cdb3), 64'd0);
      chk("arst_busy", 64'(bus.cdb_busy), 64'd0);
      model_reset();
      bus.req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_ready", 64'(bus.req_ready), 64'(ones));
      @(negedge clk);

      // Wrap-around: reach ptr=4 with holds 1,3,4 valid
      for (int i = 0; i < N; i++) begin
         t[i*TW +: TW] = TW'(10 + i);
         d[i*DW +: DW] = 32'hA000_0000 + DW'(i);
      end
      step(5'b01111, t, d, 1'b0);
      idle();
      for (int i = 0; i < N; i++) begin
         t[i*TW +: TW] = TW'(20 + i);
         d[i*DW +: DW] = 32'hB000_0000 + DW'(i);
      end
      step(5'b11010, t, d, 1'b0);
      idle();
      chk("wrap_cdb1", 64'(bus.cdb1), {26'd0, 6'd24, 32'hB000_0004});
      chk("wrap_cdb2", 64'(bus.cdb2), {26'd0, 6'd21, 32'hB000_0001});
      chk("wrap_cdb3", 64'(bus.cdb3), {26'd0, 6'd23, 32'hB000_0003});
      idle();

`ifdef CDB_ARB_FLUSH_EN
      // Flush with holds 0,1 valid and a new request on 2
      rand_vec(t, d);
      step(5'b00011, t, d, 1'b0);
      rand_vec(t, d);
      step(5'b00100, t, d, 1'b1);
      chk("flush_cdb1", 64'(bus.cdb1), 64'd0);
      chk("flush_busy", 64'(bus.cdb_busy), 64'd0);
      idle();
      chk("flush_noacc", 64'(bus.cdb1), 64'd0);
`endif

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         rand_vec(t, d);
         v  = N'($urandom);
         fl = 1'b0;
`ifdef CDB_ARB_FLUSH_EN
         fl = ($urandom_range(0, 24) == 0);
`endif
         step(v, t, d, fl);
      end
      repeat (3) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
